mem_port_arbiter: RTL and testbench

- Shares one inner memory port between the data-memory requester (MEM stage) and the instruction-fetch requester (IF stage).
- Presents the same access fields as the inner memory handshake: read/write flag, funct3 access type, address, write data and read data.
- Drives a single backend handler through a req/ack handshake, so backend latency can vary.
- Data port has priority. A streak counter stops the data port from starving instruction fetch.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the memory backend.
// master: the environment (MEM stage, IF stage, backend); slave: the arbiter itself.
interface mem_port_arbiter_if;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_rwtype;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;

  logic        m_req;
  logic        m_we;
  logic [2:0]  m_rwtype;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  modport master (
    output d_req, d_we, d_rwtype, d_addr, d_wdata,
    input  d_rdata, d_done,
    output i_req, i_addr,
    input  i_rdata, i_done,
    input  m_req, m_we, m_rwtype, m_addr, m_wdata,
    output m_rdata, m_ack
  );

  modport slave (
    input  d_req, d_we, d_rwtype, d_addr, d_wdata,
    output d_rdata, d_done,
    input  i_req, i_addr,
    output i_rdata, i_done,
    output m_req, m_we, m_rwtype, m_addr, m_wdata,
    input  m_rdata, m_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory backend between the data port (priority) and instruction fetch,
// with a streak counter that forces a fetch grant after MAX_D_STREAK contested data grants.
// Handshake: requesters hold req until their one-cycle done; backend sees m_req held
// with stable fields until a one-cycle m_ack, and m_req drops only on ack or reset.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           state_dbg,
  output logic [3:0]           streak_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [2:0] FETCH_RWTYPE = 3'b010;

  state_t      state;
  logic [3:0]  streak;
  logic        owner_fetch;
  logic        m_req_q;
  logic        m_we_q;
  logic [2:0]  m_rwtype_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] i_rdata_q;
  logic        d_done_q;
  logic        i_done_q;
  logic        grant_fetch;

  // Data wins unless it has already taken MAX_D_STREAK grants while fetch waited.
  always_comb begin
    grant_fetch = 1'b0;
    if (bus.i_req && (!bus.d_req || streak == STREAK_MAX)) grant_fetch = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      streak      <= 4'd0;
      owner_fetch <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_rwtype_q  <= 3'b000;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      i_rdata_q   <= 32'd0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
    end else begin
      d_done_q <= 1'b0;
      i_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.d_req || bus.i_req) begin
            owner_fetch <= grant_fetch;
            m_req_q     <= 1'b1;
            state       <= BUSY;
            if (grant_fetch) begin
              m_we_q     <= 1'b0;
              m_rwtype_q <= FETCH_RWTYPE;
              m_addr_q   <= bus.i_addr;
              m_wdata_q  <= 32'd0;
              streak     <= 4'd0;
            end else begin
              m_we_q     <= bus.d_we;
              m_rwtype_q <= bus.d_rwtype;
              m_addr_q   <= bus.d_addr;
              m_wdata_q  <= bus.d_wdata;
              if (!bus.i_req)               streak <= 4'd0;
              else if (streak != STREAK_MAX) streak <= streak + 4'd1;
            end
          end
        end
        BUSY: begin
          if (bus.m_ack) begin
            m_req_q <= 1'b0;
            state   <= RESP;
            if (owner_fetch) begin
              i_done_q <= 1'b1;
              if (!m_we_q) i_rdata_q <= bus.m_rdata;
            end else begin
              d_done_q <= 1'b1;
              if (!m_we_q) d_rdata_q <= bus.m_rdata;
            end
          end
        end
        RESP: begin
          // Done is visible this cycle; skipping arbitration lets the owner drop req.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_rwtype = m_rwtype_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_done   = d_done_q;
  assign bus.i_done   = i_done_q;
  assign state_dbg    = state;
  assign streak_dbg   = streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked 1 ns
// after each rising edge; expected values are hand-computed per scenario.
module tb_mem_port_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  logic [3:0] streak_dbg;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .state_dbg  (state_dbg),
    .streak_dbg (streak_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.d_req = 0; bus.d_we = 0; bus.d_rwtype = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.i_req = 0; bus.i_addr = 0; bus.m_rdata = 0; bus.m_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata, bus.d_rdata,
         bus.i_rdata, bus.d_done, bus.i_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: m_req=%b m_addr=%h d_rdata=%h i_rdata=%h done=%b%b expected all 0",
               bus.m_req, bus.m_addr, bus.d_rdata, bus.i_rdata, bus.d_done, bus.i_done);
    end
    checks++;
    if ({state_dbg, streak_dbg} !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d streak=%0d expected 0 0", state_dbg, streak_dbg);
    end
  endtask

  task automatic test_single_fetch();
    bus.i_req = 1; bus.i_addr = 32'h0000_0040;
    step();
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b0, 3'b010, 32'h40, 32'h0}) begin
      errors++;
      $display("FAIL fetch_grant: m_req=%b m_we=%b rwtype=%b addr=%h expected 1 0 010 00000040",
               bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr);
    end
    bus.m_ack = 1; bus.m_rdata = 32'h0000_0013;
    step();
    bus.m_ack = 0; bus.m_rdata = 32'hFFFF_FFFF; bus.i_req = 0;
    checks++;
    if ({bus.i_done, bus.d_done, bus.m_req, bus.i_rdata} !== {3'b100, 32'h13}) begin
      errors++;
      $display("FAIL fetch_done: i_done=%b d_done=%b m_req=%b i_rdata=%h expected 1 0 0 00000013",
               bus.i_done, bus.d_done, bus.m_req, bus.i_rdata);
    end
    step();
    checks++;
    if ({bus.i_done, bus.m_req, bus.i_rdata, state_dbg} !== {2'b00, 32'h13, 2'd0}) begin
      errors++;
      $display("FAIL fetch_hold: i_done=%b m_req=%b i_rdata=%h state=%0d expected 0 0 00000013 0",
               bus.i_done, bus.m_req, bus.i_rdata, state_dbg);
    end
  endtask

  task automatic test_store_latency();
    bus.d_req = 1; bus.d_we = 1; bus.d_rwtype = 3'b000; bus.d_addr = 32'h100; bus.d_wdata = 32'hAB;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) begin bus.m_ack = 1; bus.m_rdata = 32'h5555_5555; end
      checks++;
      if ({bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata, bus.d_done} !==
          {1'b1, 1'b1, 3'b000, 32'h100, 32'hAB, 1'b0}) begin
        errors++;
        $display("FAIL store_busy_%0d: m_req=%b we=%b rwtype=%b addr=%h wdata=%h d_done=%b expected 1 1 000 00000100 000000ab 0",
                 c, bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata, bus.d_done);
      end
    end
    step();
    bus.m_ack = 0; bus.d_req = 0; bus.d_we = 0;
    checks++;
    if ({bus.d_done, bus.i_done, bus.m_req, bus.d_rdata} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL store_done: d_done=%b i_done=%b m_req=%b d_rdata=%h expected 1 0 0 00000000",
               bus.d_done, bus.i_done, bus.m_req, bus.d_rdata);
    end
    step();
    checks++;
    if ({bus.d_done, bus.m_req} !== 2'b00) begin
      errors++;
      $display("FAIL store_after: d_done=%b m_req=%b expected 0 0", bus.d_done, bus.m_req);
    end
  endtask

  task automatic test_streak();
    logic        exp_fetch [6] = '{0, 0, 0, 0, 1, 0};
    logic [3:0]  exp_streak [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    logic [31:0] exp_d = 32'h0;
    logic [31:0] exp_i = 32'h13;
    logic [31:0] exp_addr;
    bus.d_req = 1; bus.d_we = 0; bus.d_rwtype = 3'b010; bus.d_addr = 32'h200; bus.d_wdata = 0;
    bus.i_req = 1; bus.i_addr = 32'h80;
    for (int n = 0; n < 6; n++) begin
      step();
      exp_addr = exp_fetch[n] ? 32'h80 : 32'h200;
      checks++;
      if ({bus.m_req, bus.m_addr, streak_dbg} !== {1'b1, exp_addr, exp_streak[n]}) begin
        errors++;
        $display("FAIL streak_grant_%0d: m_req=%b m_addr=%h streak=%0d expected 1 %h %0d",
                 n, bus.m_req, bus.m_addr, streak_dbg, exp_addr, exp_streak[n]);
      end
      bus.m_ack = 1; bus.m_rdata = 32'h1000 + 32'(n);
      if (exp_fetch[n]) exp_i = 32'h1000 + 32'(n);
      else              exp_d = 32'h1000 + 32'(n);
      step();
      bus.m_ack = 0;
      checks++;
      if ({bus.d_done, bus.i_done, bus.d_rdata, bus.i_rdata} !== {~exp_fetch[n], exp_fetch[n], exp_d, exp_i}) begin
        errors++;
        $display("FAIL streak_done_%0d: d_done=%b i_done=%b d_rdata=%h i_rdata=%h expected %b %b %h %h",
                 n, bus.d_done, bus.i_done, bus.d_rdata, bus.i_rdata, ~exp_fetch[n], exp_fetch[n], exp_d, exp_i);
      end
      step();
      checks++;
      if ({bus.m_req, bus.d_done, bus.i_done, state_dbg} !== {3'b000, 2'd0}) begin
        errors++;
        $display("FAIL streak_gap_%0d: m_req=%b done=%b%b state=%0d expected 0 00 0",
                 n, bus.m_req, bus.d_done, bus.i_done, state_dbg);
      end
    end
    bus.d_req = 0; bus.i_req = 0;
  endtask

  task automatic test_field_change();
    bus.d_req = 1; bus.d_we = 0; bus.d_rwtype = 3'b010; bus.d_addr = 32'h200;
    step();
    checks++;
    if ({bus.m_addr, streak_dbg} !== {32'h200, 4'd0}) begin
      errors++;
      $display("FAIL field_grant: m_addr=%h streak=%0d expected 00000200 0", bus.m_addr, streak_dbg);
    end
    bus.d_addr = 32'h300; bus.d_we = 1; bus.d_rwtype = 3'b001; bus.d_wdata = 32'h77;
    step();
    step();
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b0, 3'b010, 32'h200, 32'h0}) begin
      errors++;
      $display("FAIL field_stable: m_req=%b we=%b rwtype=%b addr=%h wdata=%h expected 1 0 010 00000200 00000000",
               bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata);
    end
    bus.m_ack = 1; bus.m_rdata = 32'hDEAD_BEEF;
    step();
    bus.m_ack = 0; bus.d_req = 0; bus.d_we = 0;
    checks++;
    if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL field_done: d_done=%b d_rdata=%h expected 1 deadbeef", bus.d_done, bus.d_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    bus.i_req = 1; bus.i_addr = 32'h44;
    step();
    step();
    rst = 1; bus.i_req = 0;
    step();
    rst = 0;
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_rwtype, bus.m_addr, bus.m_wdata, bus.d_rdata,
         bus.i_rdata, bus.d_done, bus.i_done, state_dbg, streak_dbg} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: m_req=%b m_addr=%h d_rdata=%h i_rdata=%h done=%b%b state=%0d expected all 0",
               bus.m_req, bus.m_addr, bus.d_rdata, bus.i_rdata, bus.d_done, bus.i_done, state_dbg);
    end
    step();
    checks++;
    if ({bus.m_req, bus.d_done, bus.i_done} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_nodone: m_req=%b done=%b%b expected 0 00", bus.m_req, bus.d_done, bus.i_done);
    end
    bus.i_req = 1; bus.i_addr = 32'h48;
    step();
    checks++;
    if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h48}) begin
      errors++;
      $display("FAIL midreset_regrant: m_req=%b m_addr=%h expected 1 00000048", bus.m_req, bus.m_addr);
    end
    bus.m_ack = 1; bus.m_rdata = 32'h93;
    step();
    bus.m_ack = 0; bus.i_req = 0;
    checks++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h93}) begin
      errors++;
      $display("FAIL midreset_fetch: i_done=%b i_rdata=%h expected 1 00000093", bus.i_done, bus.i_rdata);
    end
    step();
  endtask

  task automatic test_spurious_ack();
    bus.m_ack = 1; bus.m_rdata = 32'hFFFF_0000;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({state_dbg, bus.m_req, bus.d_done, bus.i_done, bus.d_rdata, bus.i_rdata} !==
          {2'd0, 3'b000, 32'h0, 32'h93}) begin
        errors++;
        $display("FAIL spurious_ack_%0d: state=%0d m_req=%b done=%b%b d_rdata=%h i_rdata=%h expected 0 0 00 00000000 00000093",
                 c, state_dbg, bus.m_req, bus.d_done, bus.i_done, bus.d_rdata, bus.i_rdata);
      end
    end
    bus.m_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_latency();
    test_streak();
    test_field_change();
    test_reset_mid_access();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
